// File: rtl/alu_pkg.sv
// Shared ALU definitions for the multiply sequencer.
// Holds the FunSel codes, the flag bit positions and the sequencer state enum.
// Optional build macro: ALU_MUL_SIGNED_EN adds the operand/result negation states.
package alu_pkg;

   // ALU function select codes
   localparam logic [4:0] FS_ADD16   = 5'b10100;
   localparam logic [4:0] FS_SUB16   = 5'b10110;
   localparam logic [4:0] FS_LSL16   = 5'b11011;
   localparam logic [4:0] FS_LSR16   = 5'b11100;
   localparam logic [4:0] FS_PASSA16 = 5'b10000;

   // Bit positions inside the {Z,C,N,O} flag vector
   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_O = 0;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_TEST,
      ST_ADD,
      ST_SHR,
      ST_SHL,
      ST_DONE
`ifdef ALU_MUL_SIGNED_EN
      ,
      ST_NEGA,
      ST_NEGB,
      ST_NEGP
`endif
   } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-add 16x16 multiplier that borrows the shared system ALU.
// Each iteration: TEST the multiplier LSB, optionally ADD the multiplicand into
// the accumulator, shift the multiplier right, shift the multiplicand left.
// Overflow is built from the ALU carry flag, which is only visible one cycle
// after the operation that produced it (hence from_add / from_shl).
// Handshake: Start is sampled only in IDLE; Busy covers accept+1 .. Done;
// Done is a single-cycle pulse and Product/Ovf are valid from Done until the
// next accept.
// Optional build macro: ALU_MUL_SIGNED_EN (adds Signed input and NEG states).
module alu_mul_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH      = 16,   // only 16 matches the ALU datapath
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
`ifdef ALU_MUL_SIGNED_EN
   input  logic             Signed,
`endif
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Product,
   output logic             Ovf,
   output logic [WIDTH-1:0] AluA,
   output logic [WIDTH-1:0] AluB,
   output logic [4:0]       AluFunSel,
   output logic             AluWF,
   input  logic [WIDTH-1:0] AluOut,
   input  logic [3:0]       AluFlags,
   output seq_state_e       state_dbg
);

   localparam int CW = $clog2(WIDTH + 1);

   seq_state_e       state, nxt;
   logic [WIDTH-1:0] acc, mcand, mplier;
   logic             from_add, from_shl;
   logic [CW-1:0]    iter;
   logic             finish;
   logic             unused_flags;

`ifdef ALU_MUL_SIGNED_EN
   logic             sgn, neg_res;
`endif

   // Only the carry flag drives decisions here
   assign unused_flags = ^{AluFlags[FLAG_Z], AluFlags[FLAG_N], AluFlags[FLAG_O]};

   assign finish    = (EARLY_EXIT && (mplier == '0)) || (iter == CW'(WIDTH));
   assign Busy      = (state != ST_IDLE);
   assign state_dbg = state;

   // Next-state and ALU command decode
   always_comb begin
      nxt       = state;
      AluA      = '0;
      AluB      = '0;
      AluFunSel = FS_PASSA16;
      AluWF     = 1'b0;
      Done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Start) begin
`ifdef ALU_MUL_SIGNED_EN
               if (Signed && OpA[WIDTH-1])      nxt = ST_NEGA;
               else if (Signed && OpB[WIDTH-1]) nxt = ST_NEGB;
               else                             nxt = ST_TEST;
`else
               nxt = ST_TEST;
`endif
            end
         end
         ST_TEST: begin
            if (finish) begin
`ifdef ALU_MUL_SIGNED_EN
               nxt = neg_res ? ST_NEGP : ST_DONE;
`else
               nxt = ST_DONE;
`endif
            end else if (mplier[0]) begin
               nxt = ST_ADD;
            end else begin
               nxt = ST_SHR;
            end
         end
         ST_ADD: begin
            AluFunSel = FS_ADD16;
            AluA      = acc;
            AluB      = mcand;
            AluWF     = 1'b1;
            nxt       = ST_SHR;
         end
         ST_SHR: begin
            AluFunSel = FS_LSR16;
            AluA      = mplier;
            AluWF     = 1'b1;
            nxt       = ST_SHL;
         end
         ST_SHL: begin
            AluFunSel = FS_LSL16;
            AluA      = mcand;
            AluWF     = 1'b1;
            nxt       = ST_TEST;
         end
         ST_DONE: begin
            Done = 1'b1;
            nxt  = ST_IDLE;
         end
`ifdef ALU_MUL_SIGNED_EN
         ST_NEGA: begin
            AluFunSel = FS_SUB16;
            AluB      = mcand;
            AluWF     = 1'b1;
            nxt       = (sgn && mplier[WIDTH-1]) ? ST_NEGB : ST_TEST;
         end
         ST_NEGB: begin
            AluFunSel = FS_SUB16;
            AluB      = mplier;
            AluWF     = 1'b1;
            nxt       = ST_TEST;
         end
         ST_NEGP: begin
            AluFunSel = FS_SUB16;
            AluB      = acc;
            AluWF     = 1'b1;
            nxt       = ST_DONE;
         end
`endif
         default: nxt = ST_IDLE;
      endcase
   end

   // State, working registers and result registers
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state    <= ST_IDLE;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         from_add <= 1'b0;
         from_shl <= 1'b0;
         iter     <= '0;
         Product  <= '0;
         Ovf      <= 1'b0;
`ifdef ALU_MUL_SIGNED_EN
         sgn      <= 1'b0;
         neg_res  <= 1'b0;
`endif
      end else begin
         state    <= nxt;
         from_add <= (state == ST_ADD);
         from_shl <= (state == ST_SHL);
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  mcand  <= OpA;
                  mplier <= OpB;
                  acc    <= '0;
                  iter   <= '0;
                  Ovf    <= 1'b0;
`ifdef ALU_MUL_SIGNED_EN
                  sgn     <= Signed;
                  neg_res <= Signed && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
`endif
               end
            end
            ST_TEST: begin
               // A multiplicand bit fell off while multiplier bits remain
               if (from_shl && AluFlags[FLAG_C] && (mplier != '0)) Ovf <= 1'b1;
               // Load the result on entry to DONE so it is valid with the pulse
               if (nxt == ST_DONE) Product <= acc;
`ifdef ALU_MUL_SIGNED_EN
               if (finish && sgn && (acc > (neg_res ? {1'b1, {(WIDTH-1){1'b0}}}
                                                    : {1'b0, {(WIDTH-1){1'b1}}})))
                  Ovf <= 1'b1;
`endif
            end
            ST_ADD: acc <= AluOut;
            ST_SHR: begin
               mplier <= AluOut;
               // Carry of the preceding ADD became visible at this cycle
               if (from_add && AluFlags[FLAG_C]) Ovf <= 1'b1;
            end
            ST_SHL: begin
               mcand <= AluOut;
               iter  <= iter + CW'(1);
            end
`ifdef ALU_MUL_SIGNED_EN
            ST_NEGA: mcand <= AluOut;
            ST_NEGB: mplier <= AluOut;
            ST_NEGP: begin
               acc     <= AluOut;
               Product <= AluOut;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer wired to a behavioural model of the system ALU.
// Expectations come from plain arithmetic on the operands (full product,
// overflow = high half nonzero, latency from OpB bit positions).
module tb_alu_mul_sequencer;
   import alu_pkg::*;

   typedef struct {
      logic [15:0] prod;
      logic        ovf;
      int          lat;
      int          acc_cyc;
      logic [15:0] b;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sgn_in;
   logic [15:0] op_a, op_b;
   logic        busy, done, ovf;
   logic [15:0] product;
   logic [15:0] alu_a, alu_b, alu_out;
   logic [4:0]  alu_fs;
   logic        alu_wf;
   logic [3:0]  alu_flags;
   logic        alu_c;
   seq_state_e  dbg_state;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          done_cnt = 0;
   logic [15:0] last_prod = '0;
   logic        last_ovf  = 1'b0;

   alu_mul_sequencer dut (
      .Clock    (clk),
      .Reset    (rst_n),
      .Start    (start),
`ifdef ALU_MUL_SIGNED_EN
      .Signed   (sgn_in),
`endif
      .OpA      (op_a),
      .OpB      (op_b),
      .Busy     (busy),
      .Done     (done),
      .Product  (product),
      .Ovf      (ovf),
      .AluA     (alu_a),
      .AluB     (alu_b),
      .AluFunSel(alu_fs),
      .AluWF    (alu_wf),
      .AluOut   (alu_out),
      .AluFlags (alu_flags),
      .state_dbg(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // ---------------- system ALU model ----------------
   always_comb begin
      alu_out = alu_a;
      alu_c   = 1'b0;
      case (alu_fs)
         5'b10100: {alu_c, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
         5'b10110: {alu_c, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
         5'b11011: {alu_c, alu_out} = {alu_a, 1'b0};
         5'b11100: begin
            alu_out = alu_a >> 1;
            alu_c   = alu_a[0];
         end
         default: alu_out = alu_a;
      endcase
   end

   always @(posedge clk) begin
      if (!rst_n) alu_flags <= 4'h0;
      else if (alu_wf)
         alu_flags <= {(alu_out == 16'h0), alu_c, alu_out[15],
                       (alu_fs == 5'b10100) && (alu_a[15] == alu_b[15]) && (alu_out[15] != alu_a[15])};
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      logic [31:0] full;
      int          k;
      full = {16'h0, a} * {16'h0, b};
      k = 0;
      for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
      e.prod    = full[15:0];
      e.ovf     = (full[31:16] != 16'h0);
      e.lat     = 3 * k + $countones(b) + 2;
      e.acc_cyc = cyc;
      e.b       = b;
      return e;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || done) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy || done) check("idle_timeout", 32'(busy), 32'd0);
   endtask

   // Returns at the negedge of the Done cycle; lat counts accept edge as cycle 0
   task automatic wait_done(output int lat);
      int n;
      n = 1;
      @(negedge clk);
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         check("done_timeout", 32'(done), 32'd1);
         exp_q.delete();
      end
      lat = n;
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] p, output logic o, output int lat);
      wait_idle();
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      @(posedge clk);
      #1;
      exp_q.push_back(model(a, b));
      start = 1'b0;
      wait_done(lat);
      p = product;
      o = ovf;
   endtask

   // ---------------- compare process ----------------
   initial begin : compare
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (done) begin
               done_cnt++;
               if (exp_q.size() == 0) begin
                  check("spurious_done", 32'(done), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("product", 32'(product), 32'(e.prod));
                  check("ovf", 32'(ovf), 32'(e.ovf));
                  check("latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
                  last_prod = e.prod;
                  last_ovf  = e.ovf;
               end
            end else if (exp_q.size() == 0) begin
               check("product_hold", 32'(product), 32'(last_prod));
               check("ovf_hold", 32'(ovf), 32'(last_ovf));
               check("idle_wf", 32'(alu_wf), 32'd0);
               check("idle_alu_ab", {alu_a, alu_b}, 32'd0);
               check("idle_funsel", 32'(alu_fs), 32'h10);
            end
            if (exp_q.size() != 0 && exp_q[0].b == 16'h0)
               check("wf_with_zero_b", 32'(alu_wf), 32'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      logic [15:0] p, a, b;
      logic        o;
      int          lat, d0;

      rst_n  = 1'b0;
      start  = 1'b0;
      sgn_in = 1'b0;
      op_a   = '0;
      op_b   = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_b", 32'(alu_b), 32'd0);
      check("rst_funsel", 32'(alu_fs), 32'h10);
      check("rst_wf", 32'(alu_wf), 32'd0);

      // 3*5 with Start held high through busy, Done and beyond
      wait_idle();
      d0    = done_cnt;
      start = 1'b1;
      op_a  = 16'd3;
      op_b  = 16'd5;
      @(posedge clk);
      #1;
      exp_q.push_back(model(16'd3, 16'd5));
      wait_done(lat);
      check("p_3x5", 32'(product), 32'h000F);
      check("o_3x5", 32'(ovf), 32'd0);
      check("lat_3x5", 32'(lat), 32'd13);
      op_a = 16'd7;
      op_b = 16'd9;
      @(negedge clk);
      check("busy_after_done_with_start", 32'(busy), 32'd0);
      check("one_done_pulse", 32'(done_cnt - d0), 32'd1);
      @(posedge clk);
      #1;
      exp_q.push_back(model(16'd7, 16'd9));
      start = 1'b0;
      wait_done(lat);
      check("p_7x9", 32'(product), 32'h003F);
      check("lat_7x9", 32'(lat), 32'd16);

      // Directed boundary cases
      run_op(16'hFFFF, 16'h0002, p, o, lat);
      check("p_ffffx2", 32'(p), 32'hFFFE);
      check("o_ffffx2", 32'(o), 32'd1);
      check("lat_ffffx2", 32'(lat), 32'd9);

      run_op(16'h0100, 16'h0100, p, o, lat);
      check("p_100x100", 32'(p), 32'h0000);
      check("o_100x100", 32'(o), 32'd1);
      check("lat_100x100", 32'(lat), 32'd30);

      run_op(16'h1234, 16'h0000, p, o, lat);
      check("p_1234x0", 32'(p), 32'h0000);
      check("o_1234x0", 32'(o), 32'd0);
      check("lat_1234x0", 32'(lat), 32'd2);

      run_op(16'h00FF, 16'h0101, p, o, lat);
      check("p_ffx101", 32'(p), 32'hFFFF);
      check("o_ffx101", 32'(o), 32'd0);

      // Randomized operands with a bias toward short and edge multipliers
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0: begin a = 16'($urandom); b = 16'($urandom); end
            1: begin a = 16'($urandom); b = 16'($urandom_range(0, 255)); end
            2: begin a = 16'($urandom_range(0, 255)); b = 16'($urandom_range(0, 255)); end
            3: begin a = 16'hFFFF; b = 16'(1 << $urandom_range(0, 15)); end
            default: begin a = 16'($urandom); b = 16'h0000; end
         endcase
         run_op(a, b, p, o, lat);
      end

      // Second Start while busy, then reset mid-run at cycle 5
      wait_idle();
      start = 1'b1;
      op_a  = 16'h00FF;
      op_b  = 16'h0F0F;
      @(posedge clk);
      #1;
      exp_q.push_back(model(16'h00FF, 16'h0F0F));
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      op_a  = 16'h1111;
      op_b  = 16'h0001;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("busy_mid_run", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      last_prod = '0;
      last_ovf  = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_product", 32'(product), 32'd0);
      check("mid_rst_ovf", 32'(ovf), 32'd0);
      d0 = done_cnt;
      repeat (20) @(negedge clk);
      check("no_done_after_reset", 32'(done_cnt - d0), 32'd0);

      // Sequencer still works after the abandoned run
      run_op(16'd12, 16'd12, p, o, lat);
      check("p_12x12", 32'(p), 32'h0090);

`ifdef ALU_MUL_SIGNED_EN
      // Signed: -3 * 5, one NEGA and one NEGP cycle added
      wait_idle();
      sgn_in = 1'b1;
      start  = 1'b1;
      op_a   = 16'hFFFD;
      op_b   = 16'd5;
      @(posedge clk);
      #1;
      exp_q.push_back('{prod: 16'hFFF1, ovf: 1'b0, lat: 15, acc_cyc: cyc, b: 16'd5});
      start  = 1'b0;
      sgn_in = 1'b0;
      wait_done(lat);
      check("p_signed", 32'(product), 32'hFFF1);
      check("o_signed", 32'(ovf), 32'd0);
`endif

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
